// File: rtl/nested_irq_ctrl.sv
// nested_irq_ctrl: prioritised interrupt controller with claim/complete handshake and a preemption stack.
// Define IRQ_NEST_EN to allow nesting up to NEST_DEPTH; otherwise a single in-service slot blocks all delivery.
module nested_irq_ctrl #(
  parameter int NUM_SRC    = 32,
  parameter int PRIO_W     = 3,
  parameter int NEST_DEPTH = 4,
  parameter int VEC_W      = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              irq_src,
  input  logic [NUM_SRC-1:0]              irq_enable,
  input  logic [NUM_SRC-1:0]              irq_edge_mode,
  input  logic [NUM_SRC*PRIO_W-1:0]       irq_prio,
  input  logic                            global_enable,
  input  logic [PRIO_W-1:0]               threshold,
  input  logic                            claim,
  input  logic                            complete,
  output logic                            irq_valid,
  output logic [VEC_W-1:0]                irq_vector,
  output logic [PRIO_W-1:0]               irq_level,
  output logic [$clog2(NEST_DEPTH+1)-1:0] nest_depth,
  output logic [NUM_SRC-1:0]              pending,
  output logic                            protocol_err
);
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);
`ifdef IRQ_NEST_EN
  localparam int STK = NEST_DEPTH;
`else
  localparam int STK = 1;
`endif

  logic [NUM_SRC-1:0] src_q_r;
  logic [NUM_SRC-1:0] in_service_r;
  logic [VEC_W-1:0]   stk_vec_r [STK];
  logic [PRIO_W-1:0]  stk_lvl_r [STK];

  logic               do_claim_s;
  logic               do_complete_s;
  logic               err_s;
  logic [DEPTH_W-1:0] depth_s;
  logic [NUM_SRC-1:0] in_service_s;
  logic [NUM_SRC-1:0] pending_s;
  logic [VEC_W-1:0]   top_vec_s;
  logic [PRIO_W-1:0]  top_lvl_s;
  logic [PRIO_W-1:0]  cur_level_s;
  logic [PRIO_W-1:0]  prio_s;
  logic               win_valid_s;
  logic [VEC_W-1:0]   win_vec_s;
  logic [PRIO_W-1:0]  win_lvl_s;

  // Handshake decode, post-handshake stack view, arbitration and pending update.
  always_comb begin
    do_claim_s    = claim & irq_valid;
    do_complete_s = complete & ~claim & (nest_depth != {DEPTH_W{1'b0}});
    err_s         = (claim & ~irq_valid) | (claim & complete) |
                    (complete & (nest_depth == {DEPTH_W{1'b0}}));

    top_vec_s = {VEC_W{1'b0}};
    for (int k = 0; k < STK; k++) begin
      top_vec_s = (k + 1 == int'(nest_depth)) ? stk_vec_r[k] : top_vec_s;
    end

    in_service_s = in_service_r;
    depth_s      = nest_depth;
    if (do_claim_s) begin
      in_service_s[irq_vector] = 1'b1;
      depth_s                  = nest_depth + DEPTH_W'(1);
    end else if (do_complete_s) begin
      in_service_s[top_vec_s] = 1'b0;
      depth_s                 = nest_depth - DEPTH_W'(1);
    end else begin
      depth_s = nest_depth;
    end

    // Arbitrate against the stack as it will be after this cycle's claim/complete.
    top_lvl_s = {PRIO_W{1'b0}};
    for (int k = 0; k < STK; k++) begin
      top_lvl_s = (k + 1 == int'(depth_s)) ? stk_lvl_r[k] : top_lvl_s;
    end
    top_lvl_s   = do_claim_s ? irq_level : top_lvl_s;
    cur_level_s = (top_lvl_s > threshold) ? top_lvl_s : threshold;

    win_valid_s = 1'b0;
    win_vec_s   = {VEC_W{1'b0}};
    win_lvl_s   = {PRIO_W{1'b0}};
    prio_s      = {PRIO_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      prio_s = irq_prio[i*PRIO_W +: PRIO_W];
      if (pending[i] && irq_enable[i] && !in_service_s[i] && global_enable &&
          (prio_s > cur_level_s) && (int'(depth_s) < STK) &&
          (!win_valid_s || (prio_s > win_lvl_s))) begin
        win_valid_s = 1'b1;
        win_vec_s   = VEC_W'(i);
        win_lvl_s   = prio_s;
      end else begin
        win_valid_s = win_valid_s;
      end
    end

    pending_s = pending;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (irq_edge_mode[i]) begin
        pending_s[i] = (pending[i] & ~(do_claim_s && (irq_vector == VEC_W'(i)))) |
                       (irq_src[i] & ~src_q_r[i]);
      end else begin
        pending_s[i] = irq_src[i];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q_r      <= {NUM_SRC{1'b0}};
      in_service_r <= {NUM_SRC{1'b0}};
      pending      <= {NUM_SRC{1'b0}};
      nest_depth   <= {DEPTH_W{1'b0}};
      irq_valid    <= 1'b0;
      irq_vector   <= {VEC_W{1'b0}};
      irq_level    <= {PRIO_W{1'b0}};
      protocol_err <= 1'b0;
      for (int k = 0; k < STK; k++) begin
        stk_vec_r[k] <= {VEC_W{1'b0}};
        stk_lvl_r[k] <= {PRIO_W{1'b0}};
      end
    end else begin
      src_q_r      <= irq_src;
      in_service_r <= in_service_s;
      pending      <= pending_s;
      nest_depth   <= depth_s;
      irq_valid    <= win_valid_s;
      irq_vector   <= win_vec_s;
      irq_level    <= win_lvl_s;
      protocol_err <= err_s;
      for (int k = 0; k < STK; k++) begin
        if (do_claim_s && (k == int'(nest_depth))) begin
          stk_vec_r[k] <= irq_vector;
          stk_lvl_r[k] <= irq_level;
        end else begin
          stk_vec_r[k] <= stk_vec_r[k];
          stk_lvl_r[k] <= stk_lvl_r[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_nested_irq_ctrl.sv
// Bench for nested_irq_ctrl: directed scenarios plus randomized traffic checked against a
// queue-based reference model of the controller's rules.
module tb_nested_irq_ctrl;
  localparam int N  = 32;
  localparam int PW = 3;
  localparam int ND = 4;
  localparam int VW = 5;
  localparam int DW = 3;
`ifdef IRQ_NEST_EN
  localparam int MD = ND;
`else
  localparam int MD = 1;
`endif
  localparam bit NEST = (MD > 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_src, irq_enable, irq_edge_mode;
  logic [N*PW-1:0] irq_prio;
  logic          global_enable;
  logic [PW-1:0] threshold;
  logic          claim, complete;
  logic          irq_valid;
  logic [VW-1:0] irq_vector;
  logic [PW-1:0] irq_level;
  logic [DW-1:0] nest_depth;
  logic [N-1:0]  pending;
  logic          protocol_err;

  always #5 clk = ~clk;

  nested_irq_ctrl #(.NUM_SRC(N), .PRIO_W(PW), .NEST_DEPTH(ND)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .irq_enable(irq_enable),
    .irq_edge_mode(irq_edge_mode), .irq_prio(irq_prio), .global_enable(global_enable),
    .threshold(threshold), .claim(claim), .complete(complete), .irq_valid(irq_valid),
    .irq_vector(irq_vector), .irq_level(irq_level), .nest_depth(nest_depth),
    .pending(pending), .protocol_err(protocol_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int vec; int lvl; } ent_t;
  ent_t stk[$];
  bit   mp[N];
  bit   mq[N];
  bit   mv;
  int   mvec;
  int   mlvl;
  bit   merr;

  function automatic int prio_of(int i);
    return int'(irq_prio[i*PW +: PW]);
  endfunction

  function automatic logic [N-1:0] mpend();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = mp[i];
    return r;
  endfunction

  // Reference model: evaluated with the inputs present just before a clock edge.
  task automatic model_tick();
    bit cok, pok, bf;
    int cvec, cur, bv, bl;
    bit insvc[N];
    ent_t e;
    if (!reset) begin
      stk.delete();
      for (int i = 0; i < N; i++) begin mp[i] = 0; mq[i] = 0; end
      mv = 0; mvec = 0; mlvl = 0; merr = 0;
      return;
    end
    cok  = claim && mv;
    pok  = complete && !claim && (stk.size() > 0);
    merr = (claim && !mv) || (complete && (claim || stk.size() == 0));
    cvec = mvec;
    if (cok) begin e.vec = mvec; e.lvl = mlvl; stk.push_back(e); end
    else if (pok) void'(stk.pop_back());
    for (int i = 0; i < N; i++) insvc[i] = 0;
    foreach (stk[k]) insvc[stk[k].vec] = 1;
    cur = int'(threshold);
    if (MD > 1 && stk.size() > 0 && stk[$].lvl > cur) cur = stk[$].lvl;
    bf = 0; bv = 0; bl = 0;
    if (global_enable && stk.size() < MD)
      for (int p = (1 << PW) - 1; p > cur && !bf; p--)
        for (int i = 0; i < N && !bf; i++)
          if (prio_of(i) == p && mp[i] && irq_enable[i] && !insvc[i]) begin bf = 1; bv = i; bl = p; end
    for (int i = 0; i < N; i++) begin
      if (irq_edge_mode[i]) mp[i] = (mp[i] && !(cok && i == cvec)) || (irq_src[i] && !mq[i]);
      else mp[i] = irq_src[i];
      mq[i] = irq_src[i];
    end
    mv = bf; mvec = bv; mlvl = bl;
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    irq_src = '0; irq_enable = '1; irq_edge_mode = '1; irq_prio = '0;
    global_enable = 1'b1; threshold = '0; claim = 1'b0; complete = 1'b0;
  endtask

  task automatic set_prio(int i, int p);
    irq_prio[i*PW +: PW] = PW'(p);
  endtask

  task automatic do_reset();
    reset = 1'b0; step(); step(); reset = 1'b1;
  endtask

  task automatic pulse(int i);
    irq_src[i] = 1'b1; step(); irq_src[i] = 1'b0;
  endtask

  task automatic test_reset();
    int ev, el;
    idle();
    irq_src = '1;
    for (int i = 0; i < N; i++) set_prio(i, $urandom_range(1, 7));
    reset = 1'b0; step(); step();
    checks++; if ({irq_valid, irq_vector, irq_level, nest_depth, protocol_err} !== '0 || pending !== '0) begin
      errors++; $display("FAIL reset_outputs got v%b vec%0d lvl%0d d%0d e%b p%h want all 0", irq_valid, irq_vector, irq_level, nest_depth, protocol_err, pending);
    end
    reset = 1'b1; step();
    checks++; if (pending !== 32'hFFFF_FFFF || irq_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release1 got pend %h valid %b want ffffffff 0", pending, irq_valid);
    end
    step();
    ev = 0; el = 0;
    for (int i = 0; i < N; i++) if (prio_of(i) > el) begin el = prio_of(i); ev = i; end
    checks++; if (irq_valid !== 1'b1 || irq_vector !== VW'(ev) || irq_level !== PW'(el)) begin
      errors++; $display("FAIL reset_release2 got v%b vec%0d lvl%0d want 1 %0d %0d", irq_valid, irq_vector, irq_level, ev, el);
    end
  endtask

  task automatic test_priority();
    idle(); do_reset();
    set_prio(2, 6); set_prio(5, 3); set_prio(9, 3);
    irq_src[2] = 1'b1; irq_src[5] = 1'b1; irq_src[9] = 1'b1; step();
    irq_src = '0; step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd2 || irq_level !== 3'd6) begin
      errors++; $display("FAIL prio_first got v%b vec%0d lvl%0d want 1 2 6", irq_valid, irq_vector, irq_level);
    end
    claim = 1'b1; step(); claim = 1'b0;
    checks++; if (irq_valid !== 1'b0 || nest_depth !== 3'd1) begin
      errors++; $display("FAIL prio_claim got v%b d%0d want 0 1", irq_valid, nest_depth);
    end
    complete = 1'b1; step(); complete = 1'b0;
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd5 || irq_level !== 3'd3 || nest_depth !== 3'd0) begin
      errors++; $display("FAIL prio_tie1 got v%b vec%0d lvl%0d d%0d want 1 5 3 0", irq_valid, irq_vector, irq_level, nest_depth);
    end
    claim = 1'b1; step(); claim = 1'b0;
    complete = 1'b1; step(); complete = 1'b0;
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd9) begin
      errors++; $display("FAIL prio_tie2 got v%b vec%0d want 1 9", irq_valid, irq_vector);
    end
    claim = 1'b1; step(); claim = 1'b0;
    complete = 1'b1; step(); complete = 1'b0;
    checks++; if (irq_valid !== 1'b0 || nest_depth !== 3'd0 || pending !== '0) begin
      errors++; $display("FAIL prio_drain got v%b d%0d p%h want 0 0 0", irq_valid, nest_depth, pending);
    end
  endtask

  task automatic test_nesting();
    int acts[8] = '{3, 0, 1, 2, 2, 0, 2, 0};
    idle(); do_reset();
    set_prio(4, 2); set_prio(7, 5);
    pulse(4); step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd4) begin
      errors++; $display("FAIL nest_first got v%b vec%0d want 1 4", irq_valid, irq_vector);
    end
    claim = 1'b1; step(); claim = 1'b0;
    checks++; if (nest_depth !== 3'd1) begin
      errors++; $display("FAIL nest_depth1 got %0d want 1", nest_depth);
    end
    for (int a = 0; a < 8; a++) begin
      claim = (acts[a] == 1) && mv;
      complete = (acts[a] == 2);
      if (acts[a] == 3) pulse(7); else step();
      claim = 1'b0; complete = 1'b0;
      checks++; if (irq_valid !== mv || irq_vector !== VW'(mvec) || nest_depth !== DW'(stk.size()) || protocol_err !== merr) begin
        errors++; $display("FAIL nest_step%0d got v%b vec%0d d%0d e%b want %b %0d %0d %b", a, irq_valid, irq_vector, nest_depth, protocol_err, mv, mvec, stk.size(), merr);
      end
    end
  endtask

  task automatic test_stack_full();
    idle(); do_reset();
    for (int k = 0; k < 4; k++) set_prio(11 + k, k + 1);
    set_prio(10, 6);
    for (int k = 0; k < 4; k++) begin
      pulse(11 + k); step();
      claim = mv; step(); claim = 1'b0;
    end
    pulse(10); step(); step();
    checks++; if (irq_valid !== 1'b0 || nest_depth !== DW'(MD)) begin
      errors++; $display("FAIL full_block got v%b d%0d want 0 %0d", irq_valid, nest_depth, MD);
    end
    complete = 1'b1; step(); complete = 1'b0;
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd10 || irq_level !== 3'd6) begin
      errors++; $display("FAIL full_release got v%b vec%0d lvl%0d want 1 10 6", irq_valid, irq_vector, irq_level);
    end
  endtask

  task automatic test_level_threshold();
    idle(); do_reset();
    irq_edge_mode[3] = 1'b0; set_prio(3, 4); threshold = 3'd4;
    irq_src[3] = 1'b1; step(); step(); step();
    checks++; if (irq_valid !== 1'b0 || pending[3] !== 1'b1) begin
      errors++; $display("FAIL lvl_thresh got v%b p3 %b want 0 1", irq_valid, pending[3]);
    end
    threshold = 3'd3; step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd3 || irq_level !== 3'd4) begin
      errors++; $display("FAIL lvl_deliver got v%b vec%0d lvl%0d want 1 3 4", irq_valid, irq_vector, irq_level);
    end
    claim = 1'b1; step(); claim = 1'b0;
    checks++; if (irq_valid !== 1'b0 || pending[3] !== 1'b1) begin
      errors++; $display("FAIL lvl_claim got v%b p3 %b want 0 1", irq_valid, pending[3]);
    end
    complete = 1'b1; step(); complete = 1'b0;
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd3) begin
      errors++; $display("FAIL lvl_redeliver got v%b vec%0d want 1 3", irq_valid, irq_vector);
    end
    irq_src[3] = 1'b0; step(); step();
    checks++; if (irq_valid !== 1'b0 || pending[3] !== 1'b0) begin
      errors++; $display("FAIL lvl_drop got v%b p3 %b want 0 0", irq_valid, pending[3]);
    end
  endtask

  task automatic test_protocol();
    idle(); do_reset();
    complete = 1'b1; step(); complete = 1'b0;
    checks++; if (protocol_err !== 1'b1 || nest_depth !== 3'd0 || irq_valid !== 1'b0) begin
      errors++; $display("FAIL proto_cmp0 got e%b d%0d v%b want 1 0 0", protocol_err, nest_depth, irq_valid);
    end
    step();
    checks++; if (protocol_err !== 1'b0) begin
      errors++; $display("FAIL proto_pulse got %b want 0", protocol_err);
    end
    claim = 1'b1; step(); claim = 1'b0;
    checks++; if (protocol_err !== 1'b1 || nest_depth !== 3'd0) begin
      errors++; $display("FAIL proto_claim0 got e%b d%0d want 1 0", protocol_err, nest_depth);
    end
    set_prio(6, 1); pulse(6); step();
    claim = 1'b1; complete = 1'b1; step(); claim = 1'b0; complete = 1'b0;
    checks++; if (protocol_err !== 1'b1 || nest_depth !== 3'd1 || irq_valid !== 1'b0) begin
      errors++; $display("FAIL proto_both got e%b d%0d v%b want 1 1 0", protocol_err, nest_depth, irq_valid);
    end
    set_prio(20, 6); pulse(20); step();
    checks++; if (irq_valid !== NEST || (NEST && irq_vector !== 5'd20)) begin
      errors++; $display("FAIL proto_preempt got v%b vec%0d want %b 20", irq_valid, irq_vector, NEST);
    end
  endtask

  task automatic test_random();
    idle(); do_reset();
    for (int i = 0; i < N; i++) set_prio(i, $urandom_range(0, 7));
    irq_edge_mode = $urandom;
    irq_enable = $urandom | $urandom | $urandom;
    for (int c = 0; c < 3000; c++) begin
      irq_src ^= ($urandom & $urandom & $urandom);
      claim = mv ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      complete = (stk.size() > 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 40) == 0);
      global_enable = ($urandom_range(0, 30) != 0);
      if ($urandom_range(0, 100) == 0) threshold = PW'($urandom_range(0, 3));
      reset = ($urandom_range(0, 500) != 0);
      step();
      checks++;
      if (irq_valid !== mv || irq_vector !== VW'(mvec) || irq_level !== PW'(mlvl) ||
          nest_depth !== DW'(stk.size()) || protocol_err !== merr || pending !== mpend()) begin
        errors++;
        $display("FAIL rand cyc %0d got v%b vec%0d lvl%0d d%0d e%b p%h want v%b vec%0d lvl%0d d%0d e%b p%h",
                 c, irq_valid, irq_vector, irq_level, nest_depth, protocol_err, pending,
                 mv, mvec, mlvl, stk.size(), merr, mpend());
      end
    end
    reset = 1'b1; claim = 1'b0; complete = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_priority();
    test_nesting();
    test_stack_full();
    test_level_threshold();
    test_protocol();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
